// File: rtl/force_release_pkg.sv
// force_release_pkg
// Shared types and helpers for the force/release observer:
//   frm_state_t    observer state encoding
//   ERR_*          bit positions inside the sticky error vector
//   LAT_MAX        deepest supported compare latency
//   sat_inc()      saturating increment used by all event counters
package force_release_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      FORCED = 2'd1,
      HOLD   = 2'd2
   } frm_state_t;

   localparam int ERR_MISMATCH = 0;
   localparam int ERR_REL_IDLE = 1;
   localparam int ERR_SIMUL    = 2;

   localparam int LAT_MAX = 4;

   // Counters are at most 32 bits wide; callers widen/narrow with casts.
   function automatic logic [31:0] sat_inc(input logic [31:0] val,
                                           input logic [31:0] max_val);
      return (val >= max_val) ? val : val + 32'd1;
   endfunction

endpackage

// File: rtl/frm_delay_line.sv
// frm_delay_line
// W-bit, LAT-deep shift register that aligns the expected net value with
// the observed net. valid rises LAT cycles after reset release, so no
// comparison ever sees the flushed reset contents. LAT=0 is a pass-through.
// Ports:
//   clk_sys   clock
//   rst_b     async active-low reset
//   d         expected value for the current cycle
//   q         expected value delayed by LAT cycles
//   valid     high once q carries post-reset data
module frm_delay_line
   import force_release_pkg::*;
#(
   parameter int W   = 1,
   parameter int LAT = 1
) (
   input  logic         clk_sys,
   input  logic         rst_b,
   input  logic [W-1:0] d,
   output logic [W-1:0] q,
   output logic         valid
);

   localparam int TW = $clog2(LAT_MAX + 1);

   generate
      if (LAT == 0) begin : g_thru
         assign q     = d;
         assign valid = 1'b1;
      end else begin : g_pipe
         logic [W-1:0]  pipe_q [LAT];
         logic [TW-1:0] wait_q;

         always_ff @(posedge clk_sys or negedge rst_b) begin
            if (!rst_b) begin
               for (int i = 0; i < LAT; i++) pipe_q[i] <= '0;
               wait_q <= TW'(LAT);
            end else begin
               pipe_q[0] <= d;
               for (int i = 1; i < LAT; i++) pipe_q[i] <= pipe_q[i-1];
               if (wait_q != '0) wait_q <= wait_q - 1'b1;
            end
         end

         assign q     = pipe_q[LAT-1];
         assign valid = (wait_q == '0);
      end
   endgenerate

endmodule

// File: rtl/force_release_monitor.sv
// force_release_monitor
// Checking end of the force/release protocol: tracks force state, builds
// the expected net value, compares it against the observed net after LAT
// cycles, counts events and raises sticky errors.
// Ports:
//   i_clk, i_rst_n        clock, async active-low reset
//   i_force, i_release    one-cycle event strobes
//   i_force_value         value applied while forced (sampled with i_force)
//   i_drv, i_net          unforced driver value, observed net value
//   i_clr                 synchronous clear of counters and error flags
//   o_forced              state is FORCED
//   o_force_cnt/o_release_cnt/o_err_cnt  saturating counters
//   o_err                 sticky flags {simul, release-not-forced, mismatch}
//
// state  | meaning
// IDLE   | net follows i_drv
// FORCED | net carries the latched force value
// HOLD   | released, net keeps force value until i_drv moves off drv_ref
module force_release_monitor
   import force_release_pkg::*;
#(
   parameter int W               = 1,
   parameter int LAT             = 1,
   parameter int HOLD_ON_RELEASE = 0,
   parameter int CW              = 8
) (
   input  logic          i_clk,
   input  logic          i_rst_n,
   input  logic          i_force,
   input  logic          i_release,
   input  logic [W-1:0]  i_force_value,
   input  logic [W-1:0]  i_drv,
   input  logic [W-1:0]  i_net,
   input  logic          i_clr,
   output logic          o_forced,
   output logic [CW-1:0] o_force_cnt,
   output logic [CW-1:0] o_release_cnt,
   output logic [CW-1:0] o_err_cnt,
   output logic [2:0]    o_err
);

   localparam logic [CW-1:0] CNT_MAX = '1;

   frm_state_t   state_q, state_nx;
   logic [W-1:0] fval_q, fval_nx;
   logic [W-1:0] drv_ref_q, drv_ref_nx;
   logic [W-1:0] exp_val, exp_dly;
   logic         cmp_vld, mismatch;
   logic         ev_release, ev_rel_idle, ev_simul;
   logic [CW-1:0] force_cnt_q, release_cnt_q, err_cnt_q;
   logic [2:0]    err_q;

   assign ev_simul = i_force & i_release;

   // Force always wins, including over a release in the same cycle.
   always_comb begin
      state_nx    = state_q;
      fval_nx     = fval_q;
      drv_ref_nx  = drv_ref_q;
      ev_release  = 1'b0;
      ev_rel_idle = 1'b0;
      if (i_force) begin
         state_nx = FORCED;
         fval_nx  = i_force_value;
      end else begin
         case (state_q)
            FORCED: begin
               if (i_release) begin
                  ev_release = 1'b1;
                  if (HOLD_ON_RELEASE != 0) begin
                     state_nx   = HOLD;
                     drv_ref_nx = i_drv;
                  end else begin
                     state_nx = IDLE;
                  end
               end
            end
            HOLD: begin
               ev_rel_idle = i_release;
               if (i_drv != drv_ref_q) state_nx = IDLE;
            end
            default: ev_rel_idle = i_release;
         endcase
      end
      // Expected value follows next-state so a strobe takes effect in its own cycle.
      exp_val = (state_nx == IDLE) ? i_drv : fval_nx;
   end

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         state_q   <= IDLE;
         fval_q    <= '0;
         drv_ref_q <= '0;
      end else begin
         state_q   <= state_nx;
         fval_q    <= fval_nx;
         drv_ref_q <= drv_ref_nx;
      end
   end

   frm_delay_line #(.W(W), .LAT(LAT)) u_dly (
      .clk_sys (i_clk),
      .rst_b   (i_rst_n),
      .d       (exp_val),
      .q       (exp_dly),
      .valid   (cmp_vld)
   );

   assign mismatch = cmp_vld & (i_net != exp_dly);

   always_ff @(posedge i_clk or negedge i_rst_n) begin
      if (!i_rst_n) begin
         force_cnt_q   <= '0;
         release_cnt_q <= '0;
         err_cnt_q     <= '0;
         err_q         <= '0;
      end else if (i_clr) begin
         force_cnt_q   <= '0;
         release_cnt_q <= '0;
         err_cnt_q     <= '0;
         err_q         <= '0;
      end else begin
         if (i_force)
            force_cnt_q <= CW'(sat_inc(32'(force_cnt_q), 32'(CNT_MAX)));
         if (ev_release)
            release_cnt_q <= CW'(sat_inc(32'(release_cnt_q), 32'(CNT_MAX)));
         if (mismatch) begin
            err_cnt_q           <= CW'(sat_inc(32'(err_cnt_q), 32'(CNT_MAX)));
            err_q[ERR_MISMATCH] <= 1'b1;
         end
         if (ev_rel_idle) err_q[ERR_REL_IDLE] <= 1'b1;
         if (ev_simul)    err_q[ERR_SIMUL]    <= 1'b1;
      end
   end

   assign o_forced      = (state_q == FORCED);
   assign o_force_cnt   = force_cnt_q;
   assign o_release_cnt = release_cnt_q;
   assign o_err_cnt     = err_cnt_q;
   assign o_err         = err_q;

endmodule
